// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl
// Brief    : Idle-detect controller producing the enable for a downstream
//            clock-gating cell. Gates the clock after IDLE_CYCLES idle edges,
//            re-opens it on activity or software disable, and raises rdy
//            WAKE_LAT edges after the clock is re-enabled.
// Options  : CG_STATS_EN - adds the saturating gated_cnt statistics output.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_LAT    = 2,
  parameter int CNT_W       = 8,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              act,
  input  logic              sw_dis,
  output logic              en,
  output logic              rdy
`ifdef CG_STATS_EN
  ,
  output logic [STAT_W-1:0] gated_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } state_t;

  // Terminal counts; both counters restart at zero on state entry so they
  // never exceed these values and cannot wrap.
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_LAT - 1);

  // Reject configurations the counters cannot represent.
  if ((IDLE_CYCLES < 1) || (WAKE_LAT < 1) || (STAT_W < 1) ||
      ((2 ** CNT_W) <= IDLE_CYCLES) || ((2 ** CNT_W) <= WAKE_LAT)) begin : g_param_check
    $error("clk_gate_ctrl: illegal parameter combination");
  end

  state_t           state;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] wake_cnt;

  // Control FSM: state, counters and the registered en/rdy outputs. en comes
  // straight from a flop so the gating cell never sees a combinational glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAKE;
      idle_cnt <= '0;
      wake_cnt <= '0;
      en       <= 1'b1;
      rdy      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (act || sw_dis) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state    <= GATED;
            idle_cnt <= '0;
            en       <= 1'b0;
            rdy      <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        GATED: begin
          if (act || sw_dis) begin
            state    <= WAKE;
            wake_cnt <= '0;
            en       <= 1'b1;
            rdy      <= 1'b0;
          end
        end
        WAKE: begin
          // act and sw_dis are deliberately ignored: a wake always completes.
          if (wake_cnt == WAKE_LAST) begin
            state    <= RUN;
            wake_cnt <= '0;
            idle_cnt <= '0;
            rdy      <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
          en <= 1'b1;
        end
        default: begin
          state    <= WAKE;
          idle_cnt <= '0;
          wake_cnt <= '0;
          en       <= 1'b1;
          rdy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CG_STATS_EN
  // Saturating count of edges spent with the clock gated; cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gated_cnt <= '0;
    end else if ((state == GATED) && (gated_cnt != {STAT_W{1'b1}})) begin
      gated_cnt <= gated_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gate_ctrl
// Brief    : Directed self-checking bench for clk_gate_ctrl with
//            IDLE_CYCLES=4, WAKE_LAT=2. Statistics checks apply when
//            CG_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic act = 1'b0;
  logic sw_dis = 1'b0;
  logic en;
  logic rdy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

`ifdef CG_STATS_EN
  logic [15:0] gated_cnt;
  logic        en_s;
  logic        rdy_s;
  logic [3:0]  gated_cnt_s;
  logic        act_s = 1'b0;
  logic        sw_dis_s = 1'b0;
`endif

  clk_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_LAT   (2),
    .CNT_W      (8),
    .STAT_W     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .act      (act),
    .sw_dis   (sw_dis),
    .en       (en),
    .rdy      (rdy)
`ifdef CG_STATS_EN
    ,
    .gated_cnt(gated_cnt)
`endif
  );

`ifdef CG_STATS_EN
  // Small-counter instance that stays idle, so it gates and then saturates.
  clk_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_LAT   (2),
    .CNT_W      (8),
    .STAT_W     (4)
  ) dut_s (
    .clk      (clk),
    .rst      (rst),
    .act      (act_s),
    .sw_dis   (sw_dis_s),
    .en       (en_s),
    .rdy      (rdy_s),
    .gated_cnt(gated_cnt_s)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset, release, and follow the wake -> run -> gate sequence.
  task automatic reset_and_gate(input string pfx);
    check({pfx, "_rst_en"}, en, 1'b1);
    check({pfx, "_rst_rdy"}, rdy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check({pfx, "_e1_rdy"}, rdy, 1'b0);
    check({pfx, "_e1_en"}, en, 1'b1);
    tick();
    check({pfx, "_e2_rdy"}, rdy, 1'b1);
    tick(3);
    check({pfx, "_run3_en"}, en, 1'b1);
    tick();
    check({pfx, "_gate_en"}, en, 1'b0);
    check({pfx, "_gate_rdy"}, rdy, 1'b0);
  endtask

  initial begin
    // Scenario 1: reset held two cycles, then release and gate.
    act = 1'b0;
    sw_dis = 1'b0;
    rst = 1'b1;
    #1;
    tick();
    reset_and_gate("s1");

    // Scenario 3: one-cycle act wake from GATED, then idle back to GATED.
    act = 1'b1;
    tick();
    act = 1'b0;
    check("s3_wake_en", en, 1'b1);
    check("s3_wake_rdy0", rdy, 1'b0);
    tick();
    check("s3_wake_rdy1", rdy, 1'b0);
    tick();
    check("s3_rdy", rdy, 1'b1);
    tick(3);
    check("s3_run3_en", en, 1'b1);
    tick();
    check("s3_gate_en", en, 1'b0);

    // Scenario 2: wake, then an act pulse after 3 idle edges restarts the count.
    act = 1'b1;
    tick();
    act = 1'b0;
    tick(2);
    check("s2_rdy", rdy, 1'b1);
    tick(3);
    check("s2_idle3_en", en, 1'b1);
    act = 1'b1;
    tick();
    act = 1'b0;
    check("s2_pulse_en", en, 1'b1);
    tick(3);
    check("s2_after3_en", en, 1'b1);
    tick();
    check("s2_after4_en", en, 1'b0);

    // Scenario 4: sw_dis held keeps the clock on; release gates after 4 edges.
    sw_dis = 1'b1;
    tick();
    check("s4_wake_en", en, 1'b1);
    tick();
    check("s4_wake_rdy", rdy, 1'b0);
    tick();
    check("s4_rdy", rdy, 1'b1);
    tick(20);
    check("s4_hold_en", en, 1'b1);
    check("s4_hold_rdy", rdy, 1'b1);
    sw_dis = 1'b0;
    tick(3);
    check("s4_rel3_en", en, 1'b1);
    tick();
    check("s4_rel4_en", en, 1'b0);

    // Scenario 5: asynchronous reset mid-cycle while gated.
    #3;
    rst = 1'b1;
    #1;
    check("s5_async_en", en, 1'b1);
    check("s5_async_rdy", rdy, 1'b0);
    reset_and_gate("s5");

`ifdef CG_STATS_EN
    // Scenario 6: ten gated edges (the last one carries the wake request).
    check("s6_cnt_start", gated_cnt, 16'd0);
    tick(9);
    act = 1'b1;
    tick();
    act = 1'b0;
    check("s6_cnt10", gated_cnt, 16'd10);
    check("s6_small10", gated_cnt_s, 4'd10);
    tick(2);
    check("s6_cnt_hold", gated_cnt, 16'd10);
    tick(10);
    check("s6_small_sat", gated_cnt_s, 4'd15);
    check("s6_small_en", en_s, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
